ddr_rx_ctrl: RTL

- Sequencer for the HDR-DDR RX deserializer during a target-driven read.
- Drives RX enable/mode through ACK -> {preamble, byte, byte, parity}* -> CRC token -> CRC value.
- Assembles 16-bit data words and reports a completion status to the DDR CCC/host logic.
- Sits between the DDR CCC FSM (start/abort/status) and the RX block (mode/mode_done/pre/error/data).

---
 rtl/ddr_rx_pkg.sv | 46 ++++
 rtl/ddr_rx_watchdog.sv | 26 ++
 rtl/ddr_rx_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ddr_rx_pkg.sv
// Shared constants for the HDR-DDR RX read sequencer: RX mode codes,
// sequencer states and completion status codes.
package ddr_rx_pkg;

  localparam int unsigned MODE_W   = 4;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned STATUS_W = 3;

  // RX deserializer mode codes
  localparam logic [MODE_W-1:0] RX_MODE_PREAMBLE  = 4'b0000;
  localparam logic [MODE_W-1:0] RX_MODE_DESER     = 4'b0011;
  localparam logic [MODE_W-1:0] RX_MODE_PARITY    = 4'b0110;
  localparam logic [MODE_W-1:0] RX_MODE_CRC_TOKEN = 4'b0111;
  localparam logic [MODE_W-1:0] RX_MODE_CRC_VALUE = 4'b1000;

  // Sequencer states
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ACK     = 3'd1;
  localparam logic [STATE_W-1:0] ST_PRE     = 3'd2;
  localparam logic [STATE_W-1:0] ST_BYTE_HI = 3'd3;
  localparam logic [STATE_W-1:0] ST_BYTE_LO = 3'd4;
  localparam logic [STATE_W-1:0] ST_PAR     = 3'd5;
  localparam logic [STATE_W-1:0] ST_CRC_TOK = 3'd6;
  localparam logic [STATE_W-1:0] ST_CRC_VAL = 3'd7;

  // Completion status codes
  localparam logic [STATUS_W-1:0] STAT_OK      = 3'd0;
  localparam logic [STATUS_W-1:0] STAT_NACK    = 3'd1;
  localparam logic [STATUS_W-1:0] STAT_PAR_ERR = 3'd2;
  localparam logic [STATUS_W-1:0] STAT_CRC_ERR = 3'd3;
  localparam logic [STATUS_W-1:0] STAT_OVERRUN = 3'd4;
  localparam logic [STATUS_W-1:0] STAT_TIMEOUT = 3'd5;
  localparam logic [STATUS_W-1:0] STAT_ABORT   = 3'd6;

  // RX mode presented while the sequencer sits in a given state
  function automatic logic [MODE_W-1:0] rx_mode_of(input logic [STATE_W-1:0] st);
    case (st)
      ST_BYTE_HI, ST_BYTE_LO: rx_mode_of = RX_MODE_DESER;
      ST_PAR:                 rx_mode_of = RX_MODE_PARITY;
      ST_CRC_TOK:             rx_mode_of = RX_MODE_CRC_TOKEN;
      ST_CRC_VAL:             rx_mode_of = RX_MODE_CRC_VALUE;
      default:                rx_mode_of = RX_MODE_PREAMBLE;
    endcase
  endfunction

endpackage

// File: rtl/ddr_rx_watchdog.sv
// Per-mode timeout counter: clears on every state change, counts while busy,
// and flags expiry once TIMEOUT_CYC-1 cycles have elapsed in one state.
module ddr_rx_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Cycle counter; saturates at the expiry value
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt_q <= '0;
    else if (clear)            cnt_q <= '0;
    else if (run && !expire_c) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign expire_c = run && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ddr_rx_ctrl.sv
// HDR-DDR RX read sequencer: walks the RX block through
// ACK -> {preamble, byte, byte, parity}* -> CRC token -> CRC value,
// assembles 16-bit words and reports a completion status.
// Optional per-mode timeout enabled by defining RX_TIMEOUT_EN.
module ddr_rx_ctrl
  import ddr_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [7:0]          i_max_words,
  input  logic                i_rx_mode_done,
  input  logic                i_rx_pre,
  input  logic                i_rx_error,
  input  logic [7:0]          i_rx_data,
  output logic                o_ddrccc_rx_en,
  output logic [MODE_W-1:0]   o_ddrccc_rx_mode,
  output logic [15:0]         o_word,
  output logic                o_word_valid,
  output logic [7:0]          o_word_cnt,
  output logic                o_busy,
  output logic                o_done,
  output logic [STATUS_W-1:0] o_status
);

  logic [STATE_W-1:0]  state_q, state_d;
  logic                guard_q, guard_d;
  logic [7:0]          max_q, max_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          lo_q, lo_d;
  logic [15:0]         word_d;
  logic                word_valid_d;
  logic [7:0]          cnt_d;
  logic                done_d;
  logic [STATUS_W-1:0] status_d;
  logic                rx_en_d;
  logic [MODE_W-1:0]   mode_d;
  logic                busy_d;
  logic                accept_c;
  logic                finish_c;
  logic [STATUS_W-1:0] fin_code_c;
  logic                timeout_c;

`ifdef RX_TIMEOUT_EN
  logic state_chg_c;
  assign state_chg_c = (state_d != state_q);

  ddr_rx_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk      (i_sys_clk),
    .rst_n    (i_sys_rst),
    .clear    (state_chg_c),
    .run      (o_busy),
    .expire_c (timeout_c)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_c      = 1'b0;
`endif

  // A mode_done in the first cycle of a new mode is a leftover and is dropped
  assign accept_c = i_rx_mode_done && !guard_q;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    max_d        = max_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    word_d       = o_word;
    word_valid_d = 1'b0;
    cnt_d        = o_word_cnt;
    done_d       = 1'b0;
    status_d     = o_status;
    finish_c     = 1'b0;
    fin_code_c   = STAT_OK;

    if (state_q == ST_IDLE) begin
      if (i_start) begin
        state_d  = ST_ACK;
        max_d    = i_max_words;
        cnt_d    = 8'd0;
        status_d = STAT_OK;
      end
    end else if (i_abort) begin
      finish_c   = 1'b1;
      fin_code_c = STAT_ABORT;
    end else if (accept_c) begin
      case (state_q)
        ST_ACK: begin
          if (i_rx_pre) begin
            finish_c   = 1'b1;
            fin_code_c = STAT_NACK;
          end else begin
            state_d = ST_PRE;
          end
        end
        ST_PRE: begin
          if (!i_rx_pre) begin
            state_d = ST_CRC_TOK;
          end else if ((max_q != 8'd0) && (o_word_cnt == max_q)) begin
            finish_c   = 1'b1;
            fin_code_c = STAT_OVERRUN;
          end else begin
            state_d = ST_BYTE_HI;
          end
        end
        ST_BYTE_HI: begin
          hi_d    = i_rx_data;
          state_d = ST_BYTE_LO;
        end
        ST_BYTE_LO: begin
          lo_d    = i_rx_data;
          state_d = ST_PAR;
        end
        ST_PAR: begin
          if (i_rx_error) begin
            finish_c   = 1'b1;
            fin_code_c = STAT_PAR_ERR;
          end else begin
            word_d       = {hi_q, lo_q};
            word_valid_d = 1'b1;
            cnt_d        = o_word_cnt + 8'd1;
            state_d      = ST_PRE;
          end
        end
        ST_CRC_TOK: state_d = ST_CRC_VAL;
        ST_CRC_VAL: begin
          finish_c   = 1'b1;
          fin_code_c = i_rx_error ? STAT_CRC_ERR : STAT_OK;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_c) begin
      finish_c   = 1'b1;
      fin_code_c = STAT_TIMEOUT;
    end

    if (finish_c) begin
      state_d  = ST_IDLE;
      done_d   = 1'b1;
      status_d = fin_code_c;
    end

    guard_d = (state_d != state_q);
    rx_en_d = (state_d != ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    mode_d  = rx_mode_of(state_d);
  end

  // State and registered outputs
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state_q          <= ST_IDLE;
      guard_q          <= 1'b0;
      max_q            <= 8'd0;
      hi_q             <= 8'd0;
      lo_q             <= 8'd0;
      o_word           <= 16'd0;
      o_word_valid     <= 1'b0;
      o_word_cnt       <= 8'd0;
      o_done           <= 1'b0;
      o_status         <= STAT_OK;
      o_ddrccc_rx_en   <= 1'b0;
      o_ddrccc_rx_mode <= RX_MODE_PREAMBLE;
      o_busy           <= 1'b0;
    end else begin
      state_q          <= state_d;
      guard_q          <= guard_d;
      max_q            <= max_d;
      hi_q             <= hi_d;
      lo_q             <= lo_d;
      o_word           <= word_d;
      o_word_valid     <= word_valid_d;
      o_word_cnt       <= cnt_d;
      o_done           <= done_d;
      o_status         <= status_d;
      o_ddrccc_rx_en   <= rx_en_d;
      o_ddrccc_rx_mode <= mode_d;
      o_busy           <= busy_d;
    end
  end

endmodule
